load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Multi-cycle data-memory access stage of the miniRISC datapath. Takes one
//   load/store command from control and runs a req/ack handshake to data
//   memory. Handles byte/halfword lane steering and sign/zero extension.
//   Its registered load_data drives the memory input of the write-back
//   4:1 operand mux.
// PARAMETERS
//   ADDR_WIDTH      32  byte-address width; mem_addr is word-aligned (addr[1:0]=0)
//   TIMEOUT_CYCLES  16  max REQ cycles without mem_ack (LSU_TIMEOUT_EN only)
//   Data path is fixed at 32 bits, little-endian, 4 byte lanes.
// PORTS
//   clk         in   1           single clock, rising edge
//   rst_n       in   1           asynchronous, active-low reset
//   start       in   1           command valid; sampled only in IDLE
//   is_load     in   1           1 = load, 0 = store
//   size        in   2           00 byte, 01 half, 10 word, 11 illegal
//   sign_ext    in   1           loads: 1 sign-extend, 0 zero-extend
//   addr        in   ADDR_WIDTH  byte address
//   wdata       in   32          store data, right-justified
//   busy        out  1           high in any state other than IDLE
//   done        out  1           one-cycle completion pulse
//   load_data   out  32          formatted load result; held until next load
//   misaligned  out  1           valid with done: command rejected
//   timeout     out  1           valid with done: handshake aborted
//   mem_req     out  1           memory request, held until mem_ack
//   mem_we      out  1           1 = write
//   mem_addr    out  ADDR_WIDTH  {addr[ADDR_WIDTH-1:2],2'b00}
//   mem_be      out  4           byte enables
//   mem_wdata   out  32          store data replicated across lanes
//   mem_ack     in   1           memory accepted/returned; sampled only in REQ
//   mem_rdata   in   32          read data, valid in the mem_ack cycle
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE. busy, done, misaligned, timeout,
//     mem_req, mem_we = 0. mem_addr, mem_be, mem_wdata, load_data = 0.
//     mem_req drops immediately; an in-flight access is abandoned and no done.
//   FSM: IDLE -> REQ (start, legal) | ERR (start, illegal);
//     REQ -> DONE on mem_ack; ERR -> IDLE; DONE -> IDLE.
//   Legality: byte always legal; half needs addr[0]=0; word needs addr[1:0]=0;
//     size=11 is always illegal. Illegal commands: no memory access.
//     In ERR: done=1 and misaligned=1 for one cycle. load_data is unchanged.
//   REQ: mem_req=1. mem_we, mem_addr, mem_be, mem_wdata are registered at
//     start and stay stable until mem_ack.
//     mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'hF.
//     mem_wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
//   On mem_ack in REQ: for a load, extract the addressed lane of mem_rdata.
//     Extend it per sign_ext and register it into load_data.
//     Then mem_req=0 and go to DONE.
//   DONE: done=1 for one cycle. Stores leave load_data unchanged.
//   Latency: start at cycle N, mem_req from N+1. Ack at cycle N+k gives
//     done at N+k+1 (minimum 2 cycles).
//   start while busy is ignored, not queued. mem_ack outside REQ is ignored.
//   start in the same cycle done is high is ignored (state is DONE, not IDLE).
// CONFIGURATION
//   LSU_TIMEOUT_EN defined: a counter runs in REQ and clears on entry.
//     If TIMEOUT_CYCLES cycles pass with no mem_ack: mem_req drops, go to DONE,
//     done=1 and timeout=1. load_data is unchanged.
//     An ack in the final counted cycle wins over the timeout.
//   LSU_TIMEOUT_EN undefined: no counter; timeout tied 0; REQ waits forever.
// TESTING
//   1 lw addr=0x100, ack 1st REQ cycle, rdata=0xDEADBEEF -> mem_be=F,
//     done at start+2, load_data=0xDEADBEEF.
//   2 lb sign_ext=1 addr=0x103, rdata=0x80FF_FFFF -> mem_be=4'b1000,
//     load_data=0xFFFF_FF80; lbu -> 0x0000_0080.
//   3 sh addr=0x102 wdata=0x1234ABCD, ack after 3 wait cycles ->
//     mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_req high 4 cycles, done once.
//   4 lw addr=0x101, then size=11 -> no mem_req, done+misaligned pulse at
//     start+1 each time, load_data unchanged.
//   5 rst_n=0 mid-REQ -> mem_req=0 immediately, all outputs 0, no done;
//     start after release works normally.
//   6 LSU_TIMEOUT_EN, no ack -> done+timeout after 16 REQ cycles;
//     ack on the 16th cycle -> normal done, timeout=0.

Source files
------------

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Multi-cycle data-memory access stage of the miniRISC datapath. Accepts one
//   load/store command at a time and runs a req/ack handshake with data memory.
//   It steers byte and halfword lanes and applies sign or zero extension. The
//   registered load_data feeds the memory input of the write-back operand mux.
//
//   Optional feature macro: LSU_TIMEOUT_EN. When it is defined, an access that
//   sees no mem_ack for TIMEOUT_CYCLES REQ cycles is aborted with done+timeout.
//   When it is undefined, REQ waits forever and timeout is tied low.
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start              command valid, sampled only in IDLE
//   is_load            1 = load, 0 = store
//   size               00 byte, 01 half, 10 word, 11 illegal
//   sign_ext           loads: 1 = sign-extend, 0 = zero-extend
//   addr               byte address
//   wdata              store data, right-justified
//   busy               high in every state except IDLE
//   done               one-cycle completion pulse
//   load_data          formatted load result, held until the next load
//   misaligned         valid with done: command rejected
//   timeout            valid with done: handshake aborted
//   mem_req            memory request, held until mem_ack
//   mem_we             1 = write
//   mem_addr           word-aligned address
//   mem_be             byte enables
//   mem_wdata          store data replicated across lanes
//   mem_ack            memory accepted/returned, sampled only in REQ
//   mem_rdata          read data, valid in the mem_ack cycle
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  is_load,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           load_data,
  output logic                  misaligned,
  output logic                  timeout,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ERR  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // A zero-cycle timeout would make REQ meaningless; reject it at elaboration.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("load_store_unit: TIMEOUT_CYCLES must be at least 1");
  end

  state_t                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  misaligned_q;
  logic                  timeout_q;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [3:0]            mem_be_q;
  logic [31:0]           mem_wdata_q;
  logic [31:0]           load_data_q;
  // Command attributes kept for formatting the returned load data.
  logic [1:0]            size_q;
  logic                  sext_q;
  logic [1:0]            off_q;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q;
`endif

  // Alignment rule: halves need an even address, words a multiple of four.
  function automatic logic is_legal(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   is_legal = 1'b1;
      2'b01:   is_legal = ~off[0];
      2'b10:   is_legal = (off == 2'b00);
      default: is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   lane_be = 4'b0001 << off;
      2'b01:   lane_be = 4'b0011 << {off[1], 1'b0};
      2'b10:   lane_be = 4'b1111;
      default: lane_be = 4'b0000;
    endcase
  endfunction

  // Replicating store data lets memory pick it up on whichever lane is enabled.
  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      2'b00:   lane_wdata = {4{wd[7:0]}};
      2'b01:   lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend it to 32 bits.
  function automatic logic [31:0] fmt_load(input logic [1:0] sz, input logic sx,
                                           input logic [1:0] off, input logic [31:0] rd);
    logic [15:0] lane;
    lane = 16'(rd >> {off, 3'b000});
    case (sz)
      2'b00:   fmt_load = {{24{sx & lane[7]}}, lane[7:0]};
      2'b01:   fmt_load = {{16{sx & lane[15]}}, lane[15:0]};
      default: fmt_load = rd;
    endcase
  endfunction

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= 4'b0000;
      mem_wdata_q  <= 32'h0000_0000;
      load_data_q  <= 32'h0000_0000;
      size_q       <= 2'b00;
      sext_q       <= 1'b0;
      off_q        <= 2'b00;
`ifdef LSU_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      // Status flags are single-cycle pulses unless re-asserted below.
      done_q       <= 1'b0;
      misaligned_q <= 1'b0;
      timeout_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (is_legal(size, addr[1:0])) begin
              state_q     <= S_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= ~is_load;
              mem_addr_q  <= {addr[ADDR_WIDTH-1:2], 2'b00};
              mem_be_q    <= lane_be(size, addr[1:0]);
              mem_wdata_q <= lane_wdata(size, wdata);
              size_q      <= size;
              sext_q      <= sign_ext;
              off_q       <= addr[1:0];
`ifdef LSU_TIMEOUT_EN
              cnt_q       <= '0;
`endif
            end else begin
              // Rejected commands never touch memory.
              state_q      <= S_ERR;
              done_q       <= 1'b1;
              misaligned_q <= 1'b1;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            if (!mem_we_q) begin
              load_data_q <= fmt_load(size_q, sext_q, off_q, mem_rdata);
            end else begin
              load_data_q <= load_data_q;
            end
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
`ifdef LSU_TIMEOUT_EN
          // An ack in the last counted cycle is taken above, so it wins.
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
`else
          end else begin
            state_q <= S_REQ;
`endif
          end
        end
        S_ERR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q    <= 1'b0;
          mem_req_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign misaligned = misaligned_q;
  assign timeout    = timeout_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign load_data  = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed commands, a transaction-level model of
// the expected outputs per cycle, and one compare process on the falling edge.
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, misaligned, timeout, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .load_data(load_data), .misaligned(misaligned), .timeout(timeout),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int n_chk = 0, n_pass = 0;
  int cyc_cnt = 0, done_cnt = 0, req_cnt = 0, last_done_cyc = 0, t_start = 0;
  logic [3:0]  cap_be = 4'h0;
  logic [31:0] cap_wdata = 32'h0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle.
  bit          exp_busy = 0, exp_done = 0, exp_mis = 0, exp_to = 0, exp_req = 0, exp_we = 0;
  logic [31:0] exp_addr = 32'h0, exp_wdata = 32'h0, exp_ld = 32'h0;
  logic [3:0]  exp_be = 4'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%08h, want 0x%08h", nm, cyc_cnt, act, exp);
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit ref_legal(input logic [1:0] sz, input logic [31:0] a);
    return (sz != 2'd3) && ((int'(a[1:0]) % nbytes(sz)) == 0);
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] a);
    int m;
    m = ((1 << nbytes(sz)) - 1) << int'(a[1:0]);
    return 4'(m);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return {24'h0, wd[7:0]} * 32'h0101_0101;
    else if (sz == 2'd1) return {16'h0, wd[15:0]} * 32'h0001_0001;
    else return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit sx,
                                           input logic [31:0] a, input logic [31:0] rd);
    longint v;
    int nb, off;
    nb  = nbytes(sz);
    off = int'(a[1:0]);
    v = (longint'(rd) >> (8 * off)) & ((longint'(1) << (8 * nb)) - 1);
    if (sx && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  // Compare process: every falling edge, DUT against the model.
  initial begin
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (mem_req) begin req_cnt++; cap_be = mem_be; cap_wdata = mem_wdata; end
      if (done) begin done_cnt++; last_done_cyc = cyc_cnt; end
      if (chk_en) begin
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(exp_done));
        chk("misaligned", 32'(misaligned), 32'(exp_mis));
        chk("timeout", 32'(timeout), 32'(exp_to));
        chk("mem_req", 32'(mem_req), 32'(exp_req));
        chk("load_data", load_data, exp_ld);
        if (exp_req) begin
          chk("mem_we", 32'(mem_we), 32'(exp_we));
          chk("mem_addr", mem_addr, exp_addr);
          chk("mem_be", 32'(mem_be), 32'(exp_be));
          chk("mem_wdata", mem_wdata, exp_wdata);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One full command from an idle DUT. wt = wait cycles before ack; noisy
  // drives stray start/mem_ack where they must be ignored.
  task automatic run_cmd(input bit ld, input logic [1:0] sz, input bit sx,
                         input logic [31:0] a, input logic [31:0] wd, input int wt,
                         input logic [31:0] rd, input bit noisy);
    int nreq;
    bit tmo;
    start = 1'b1; is_load = ld; size = sz; sign_ext = sx; addr = a; wdata = wd;
    mem_ack = noisy; mem_rdata = $urandom;
    exp_busy = 0; exp_done = 0; exp_mis = 0; exp_to = 0; exp_req = 0;
    t_start = cyc_cnt + 1;
    if (!ref_legal(sz, a)) begin
      cyc();
      start = noisy; mem_ack = 1'b0;
      exp_busy = 1; exp_done = 1; exp_mis = 1;
      cyc();
      start = 1'b0;
      exp_busy = 0; exp_done = 0; exp_mis = 0;
      return;
    end
    if (TMO_EN && wt >= TMO) begin nreq = TMO; tmo = 1'b1; end
    else begin nreq = wt + 1; tmo = 1'b0; end
    for (int i = 1; i <= nreq; i++) begin
      cyc();
      if (i == 1) begin
        exp_busy = 1; exp_req = 1; exp_we = !ld; exp_addr = {a[31:2], 2'b00};
        exp_be = ref_be(sz, a); exp_wdata = ref_wdata(sz, wd);
      end
      start = noisy;
      if (noisy) begin is_load = ~ld; addr = ~a; end
      mem_ack = !tmo && (i == nreq);
      mem_rdata = mem_ack ? rd : $urandom;
    end
    cyc();
    exp_req = 0; exp_done = 1; exp_to = tmo;
    if (ld && !tmo) exp_ld = ref_load(sz, sx, a, rd);
    start = noisy; mem_ack = noisy; mem_rdata = $urandom;
    cyc();
    exp_done = 0; exp_to = 0; exp_busy = 0;
    start = 1'b0;
  endtask

  initial begin
    #1 chk_en = 1'b1;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_load_data", load_data, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);

    // lw, immediate ack
    run_cmd(1'b1, 2'b10, 1'b0, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    chk("t1_ld", load_data, 32'hDEAD_BEEF);
    chk("t1_latency", 32'(last_done_cyc - t_start), 32'd2);
    chk("t1_be", 32'(cap_be), 32'hF);

    // lb / lbu on the top lane
    run_cmd(1'b1, 2'b00, 1'b1, 32'h103, 32'h0, 1, 32'h80FF_FFFF, 1'b0);
    chk("t2_lb", load_data, 32'hFFFF_FF80);
    chk("t2_be", 32'(cap_be), 32'h8);
    run_cmd(1'b1, 2'b00, 1'b0, 32'h103, 32'h0, 0, 32'h80FF_FFFF, 1'b1);
    chk("t2_lbu", load_data, 32'h0000_0080);

    // sh with three wait cycles and stray start/ack
    req_cnt = 0; done_cnt = 0;
    run_cmd(1'b0, 2'b01, 1'b0, 32'h102, 32'h1234_ABCD, 3, 32'h0, 1'b1);
    chk("t3_be", 32'(cap_be), 32'hC);
    chk("t3_wdata", cap_wdata, 32'hABCD_ABCD);
    chk("t3_req_cycles", 32'(req_cnt), 32'd4);
    chk("t3_done_count", 32'(done_cnt), 32'd1);
    chk("t3_ld_kept", load_data, 32'h0000_0080);

    // more lanes and extensions
    run_cmd(1'b1, 2'b01, 1'b1, 32'h202, 32'h0, 2, 32'h8001_7FFF, 1'b0);
    chk("lh_upper", load_data, 32'hFFFF_8001);
    run_cmd(1'b1, 2'b01, 1'b0, 32'h200, 32'h0, 0, 32'h1234_F00D, 1'b0);
    chk("lhu_lower", load_data, 32'h0000_F00D);
    run_cmd(1'b0, 2'b00, 1'b0, 32'h301, 32'h0000_AA55, 0, 32'h0, 1'b0);
    chk("sb_be", 32'(cap_be), 32'h2);
    chk("sb_wdata", cap_wdata, 32'h5555_5555);
    run_cmd(1'b0, 2'b10, 1'b0, 32'h400, 32'h0BAD_F00D, 20, 32'h0, 1'b1);

    // illegal commands
    req_cnt = 0; done_cnt = 0;
    run_cmd(1'b1, 2'b10, 1'b0, 32'h101, 32'h0, 0, 32'h0, 1'b0);
    chk("t4_latency", 32'(last_done_cyc - t_start), 32'd1);
    run_cmd(1'b1, 2'b11, 1'b0, 32'h100, 32'h0, 0, 32'h0, 1'b1);
    run_cmd(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 0, 32'h0, 1'b0);
    chk("t4_no_req", 32'(req_cnt), 32'd0);
    chk("t4_done_count", 32'(done_cnt), 32'd3);

    // reset in the middle of REQ
    start = 1'b1; is_load = 1'b1; size = 2'b10; addr = 32'h500; mem_ack = 1'b0;
    cyc();
    start = 1'b0;
    exp_busy = 1; exp_req = 1; exp_we = 0; exp_addr = 32'h500;
    exp_be = 4'hF; exp_wdata = ref_wdata(2'b10, wdata);
    #2 rst_n = 1'b0;
    exp_busy = 0; exp_req = 0; exp_ld = 32'h0;
    #1;
    chk("t5_req_now", 32'(mem_req), 32'h0);
    chk("t5_busy_now", 32'(busy), 32'h0);
    chk("t5_be_now", 32'(mem_be), 32'h0);
    chk("t5_ld_now", load_data, 32'h0);
    done_cnt = 0;
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    run_cmd(1'b1, 2'b10, 1'b0, 32'h104, 32'h0, 1, 32'hCAFE_F00D, 1'b0);
    chk("t5_after", load_data, 32'hCAFE_F00D);

`ifdef LSU_TIMEOUT_EN
    run_cmd(1'b1, 2'b10, 1'b0, 32'h600, 32'h0, 15, 32'h1357_9BDF, 1'b0);
    chk("t6_last_ack", load_data, 32'h1357_9BDF);
    req_cnt = 0;
    run_cmd(1'b1, 2'b10, 1'b0, 32'h604, 32'h0, 40, 32'h0, 1'b0);
    chk("t6_req_cycles", 32'(req_cnt), 32'd16);
    chk("t6_ld_kept", load_data, 32'h1357_9BDF);
`endif

    cyc();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
